sdram_bus_bridge: RTL and testbench
===================================

Name: sdram_bus_bridge

Overview:
- Upstream adapter feeding the SDRAM controller's 16-bit host port from a 32-bit CPU/bus side.
- Latches one 32-bit request and splits it into zero, one or two 16-bit controller accesses, skipping any halfword whose byte enables are both zero.
- Reassembles read data and returns a single-cycle acknowledge.
- Holds off all traffic until the controller's power-up initialisation has finished, and ignores stray completions.

Parameters:
- clkf, 50000000, system clock frequency in Hz.
- INIT_CYCLES, 5100, cycles after reset before the first controller access. Covers controller init of 100 us plus PRE/REF/REF/MRS at clkf.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- b_addr  input  32  bus byte address; bits [1:0] ignored.
- b_wdata  input  32  bus write data.
- b_bytesel  input  4  bus byte enables; bit0 = byte 0.
- b_wr_en  input  1  1 = write, 0 = read.
- b_access  input  1  request strobe; sampled only in IDLE.
- b_rdata  output  32  read data; valid while b_ack is high.
- b_ack  output  1  one-cycle completion pulse.
- b_ready  output  1  high once the init wait has expired.
- h_addr  output  32  to controller.
- h_wdata  output  16  to controller.
- h_rdata  input  16  from controller.
- h_wr_en  output  1  to controller.
- h_bytesel  output  2  to controller; active-high byte enables.
- h_compl  input  1  controller completion pulse.

Behaviour:
- Reset values:
  - state = INIT; init counter = 0.
  - All outputs 0: b_rdata, b_ack, b_ready, h_addr, h_wdata, h_wr_en, h_bytesel.
- Controller contract:
  - The controller starts an access when h_bytesel != 0 and h_compl is low while it is idle.
  - It pulses h_compl for one cycle at the end of the access.
  - On read completion, h_rdata is valid in the same cycle as h_compl.
  - h_addr, h_wdata, h_wr_en and h_bytesel are all registered. They are held stable from issue until the h_compl cycle.
- States: INIT, IDLE, LO, HI, ACK.
- INIT:
  - Counter increments each cycle; h_compl is ignored.
  - When counter reaches INIT_CYCLES-1: go to IDLE and set b_ready=1 on the next edge.
- IDLE:
  - h_compl is ignored.
  - When b_access=1, latch b_addr[31:2], b_wdata, b_bytesel and b_wr_en, and clear the rdata latch to 0.
  - Next state:
    - b_bytesel[1:0] != 0: LO.
    - else b_bytesel[3:2] != 0: HI.
    - else: ACK, with no SDRAM access.
  - b_access during INIT, or in any state other than IDLE, is ignored. The bus master holds its request until b_ack.
- LO:
  - Drive h_addr = {a[31:2],2'b00}, h_wdata = wd[15:0], h_bytesel = be[1:0], h_wr_en = wr.
  - On h_compl:
    - Capture h_rdata into rdata[15:0] for reads.
    - Go to HI if be[3:2] != 0, else to ACK.
- HI:
  - Drive h_addr = {a[31:2],2'b10}, h_wdata = wd[31:16], h_bytesel = be[3:2], h_wr_en = wr.
  - On h_compl: capture rdata[31:16] for reads; go to ACK.
- LO to HI hand-off:
  - The new address and bytesel appear on the edge after the h_compl cycle.
  - The controller is blocked from restarting during the h_compl cycle itself, so no duplicate access occurs.
- ACK:
  - b_ack=1 for exactly one cycle; b_rdata = rdata. Unaccessed halves read as 0.
  - h_bytesel=0 and h_wr_en=0.
  - Next state: IDLE.
- h_wr_en and h_bytesel are 0 in every state other than LO and HI. This keeps the controller's data bus tri-stated when idle.
- Writes: b_rdata = 0 at ack.
- Access latency:
  - Two-halfword access: b_ack arrives 2 + (LO access) + (HI access) cycles after b_access.
  - Zero-enable access: b_ack arrives 2 cycles after b_access.
- Reset mid-operation:
  - All outputs drop immediately and the state returns to INIT.
  - A controller access already in flight completes and its h_compl falls inside the INIT window, where it is ignored.
  - Write data of an interrupted write is undefined in SDRAM; this is accepted.
- The controller's own h_compl pulse at the end of its init (MRS) occurs during INIT and is ignored.

Decomposition:
- Shared package sdram_pkg holds:
  - state encodings (INIT/IDLE/LO/HI/ACK);
  - HALF_LO = 2'b00 and HALF_HI = 2'b10 address suffixes;
  - a function computing the default INIT_CYCLES from clkf.
- One sub-module: the existing counter block, reused for the INIT wait. Width is $clog2(INIT_CYCLES).
- Everything else is inline.

Test Plan:
- Init hold-off: b_access=1 from cycle 10 with bytesel=4'hF.
  - h_bytesel stays 0 and b_ready stays 0 until cycle INIT_CYCLES.
  - A h_compl pulse injected at cycle 3000 produces no b_ack.
- Full 32-bit write: addr 0x00000104, wdata 0xDEADBEEF, be 4'hF.
  - First controller access: h_addr 0x104, h_wdata 0xBEEF, h_bytesel 2'b11.
  - Second controller access: h_addr 0x106, h_wdata 0xDEAD.
  - Exactly one b_ack, after the second h_compl.
- Full 32-bit read: controller model returns 0x1234 then 0x5678.
  - b_rdata = 0x56781234 in the b_ack cycle.
- Partial accesses:
  - be 4'b1000 read: only HI access, h_bytesel = 2'b10; b_rdata = {h_rdata,16'h0000}.
  - be 4'b0000: b_ack two cycles after b_access, with no h_bytesel activity.
- Hand-off check: with a controller model that restarts whenever h_bytesel != 0 && !h_compl, each 32-bit access produces exactly two controller starts, never three.
- Async reset: assert rst_n=0 during HI of a write.
  - h_wr_en and h_bytesel are 0 within the same cycle.
  - The trailing h_compl is ignored.
  - A new request after INIT_CYCLES completes normally.

Source files
------------

// File: rtl/sdram_bus_bridge_pkg.sv
// Shared types and constants for the 32-to-16-bit SDRAM host-port bridge.
package sdram_pkg;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_LO, ST_HI, ST_ACK} state_t;

    localparam logic [1:0] HALF_LO = 2'b00;
    localparam logic [1:0] HALF_HI = 2'b10;

    // 100 us of controller power-up wait plus a margin for PRE/REF/REF/MRS.
    function automatic int init_cycles(input int clkf);
        return (clkf / 10000) + 100;
    endfunction

endpackage

// File: rtl/sdram_bus_bridge_if.sv
// Bus-side and controller-side signals of the bridge; slave = bridge, master = environment.
interface sdram_bus_bridge_if;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_bytesel;
    logic        b_wr_en;
    logic        b_access;
    logic [31:0] b_rdata;
    logic        b_ack;
    logic        b_ready;
    logic [31:0] h_addr;
    logic [15:0] h_wdata;
    logic [15:0] h_rdata;
    logic        h_wr_en;
    logic [1:0]  h_bytesel;
    logic        h_compl;

    modport slave (
        input  b_addr, b_wdata, b_bytesel, b_wr_en, b_access, h_rdata, h_compl,
        output b_rdata, b_ack, b_ready, h_addr, h_wdata, h_wr_en, h_bytesel
    );

    modport master (
        output b_addr, b_wdata, b_bytesel, b_wr_en, b_access, h_rdata, h_compl,
        input  b_rdata, b_ack, b_ready, h_addr, h_wdata, h_wr_en, h_bytesel
    );
endinterface

// File: rtl/sdram_bus_bridge_counter.sv
// Free-running enabled up-counter, cleared only by reset.
module sdram_bus_bridge_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/sdram_bus_bridge.sv
// Splits a latched 32-bit bus request into up to two 16-bit SDRAM controller
// accesses, skipping halfwords with no byte enables, and reassembles read data.
module sdram_bus_bridge
    import sdram_pkg::*;
#(
    parameter int clkf        = 50000000,
    parameter int INIT_CYCLES = init_cycles(clkf)
) (
    input logic             clk,
    input logic             rst_n,
    sdram_bus_bridge_if.slave bus
);
    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] init_cnt;
    logic [29:0]   a;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic          wr;
    logic [31:0]   rdata;

    sdram_bus_bridge_counter #(.W(CW)) u_init_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_INIT),
        .count (init_cnt)
    );

    // Controller-side outputs are loaded on the edge that enters LO/HI and held
    // until the h_compl cycle, so the controller never sees a half-updated access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            a             <= '0;
            wd            <= '0;
            be            <= '0;
            wr            <= 1'b0;
            rdata         <= '0;
            bus.b_rdata   <= '0;
            bus.b_ack     <= 1'b0;
            bus.b_ready   <= 1'b0;
            bus.h_addr    <= '0;
            bus.h_wdata   <= '0;
            bus.h_wr_en   <= 1'b0;
            bus.h_bytesel <= '0;
        end else begin
            bus.b_ack <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state       <= ST_IDLE;
                        bus.b_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.b_access) begin
                        a     <= bus.b_addr[31:2];
                        wd    <= bus.b_wdata;
                        be    <= bus.b_bytesel;
                        wr    <= bus.b_wr_en;
                        rdata <= '0;
                        if (|bus.b_bytesel[1:0]) begin
                            state         <= ST_LO;
                            bus.h_addr    <= {bus.b_addr[31:2], HALF_LO};
                            bus.h_wdata   <= bus.b_wdata[15:0];
                            bus.h_bytesel <= bus.b_bytesel[1:0];
                            bus.h_wr_en   <= bus.b_wr_en;
                        end else if (|bus.b_bytesel[3:2]) begin
                            state         <= ST_HI;
                            bus.h_addr    <= {bus.b_addr[31:2], HALF_HI};
                            bus.h_wdata   <= bus.b_wdata[31:16];
                            bus.h_bytesel <= bus.b_bytesel[3:2];
                            bus.h_wr_en   <= bus.b_wr_en;
                        end else begin
                            state       <= ST_ACK;
                            bus.b_ack   <= 1'b1;
                            bus.b_rdata <= '0;
                        end
                    end
                end
                ST_LO: begin
                    if (bus.h_compl) begin
                        if (!wr) rdata[15:0] <= bus.h_rdata;
                        if (|be[3:2]) begin
                            state         <= ST_HI;
                            bus.h_addr    <= {a, HALF_HI};
                            bus.h_wdata   <= wd[31:16];
                            bus.h_bytesel <= be[3:2];
                        end else begin
                            state         <= ST_ACK;
                            bus.b_ack     <= 1'b1;
                            bus.b_rdata   <= {16'h0000, wr ? 16'h0000 : bus.h_rdata};
                            bus.h_bytesel <= '0;
                            bus.h_wr_en   <= 1'b0;
                        end
                    end
                end
                ST_HI: begin
                    if (bus.h_compl) begin
                        if (!wr) rdata[31:16] <= bus.h_rdata;
                        state         <= ST_ACK;
                        bus.b_ack     <= 1'b1;
                        bus.b_rdata   <= {wr ? 16'h0000 : bus.h_rdata, rdata[15:0]};
                        bus.h_bytesel <= '0;
                        bus.h_wr_en   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state       <= ST_IDLE;
                    bus.b_rdata <= '0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Directed bench for sdram_bus_bridge with a small SDRAM controller model.
module tb_sdram_bus_bridge;
    localparam int INIT_CYCLES = 5100;
    localparam int LAT         = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sdram_bus_bridge_if bif ();

    sdram_bus_bridge #(.clkf(50000000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int acks = 0;
    always @(posedge clk) if (bif.b_ack === 1'b1) acks <= acks + 1;

    // Controller model: starts when idle and it sees h_bytesel != 0 with h_compl low.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic        m_compl = 1'b0;
    logic [15:0] m_rdata = 16'h0;
    logic [31:0] m_addr = 32'h0;
    logic        inj_compl = 1'b0;
    logic [15:0] rd_lo = 16'h0, rd_hi = 16'h0;
    int          n_start = 0;
    logic [31:0] lg_addr [16];
    logic [15:0] lg_wd   [16];
    logic [1:0]  lg_be   [16];
    logic        lg_wr   [16];

    assign bif.h_compl = m_compl | inj_compl;
    assign bif.h_rdata = m_rdata;

    always @(posedge clk) begin
        m_compl <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy  <= 1'b0;
                m_compl <= 1'b1;
                m_rdata <= m_addr[1] ? rd_hi : rd_lo;
            end else m_cnt <= m_cnt - 1;
        end else if (bif.h_bytesel != 2'b00 && !bif.h_compl) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_addr <= bif.h_addr;
            lg_addr[n_start % 16] <= bif.h_addr;
            lg_wd[n_start % 16]   <= bif.h_wdata;
            lg_be[n_start % 16]   <= bif.h_bytesel;
            lg_wr[n_start % 16]   <= bif.h_wr_en;
            n_start <= n_start + 1;
        end
    end

    // ncyc counts the request cycle as 1.
    task automatic wait_ack(input string tag, output logic [31:0] rd, output int ncyc);
        ncyc = 1;
        while (bif.b_ack !== 1'b1 && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
        end
        chk({tag, " ack seen"}, {31'h0, bif.b_ack}, 32'h1);
        rd = bif.b_rdata;
        bif.b_access = 1'b0;
    endtask

    task automatic do_acc(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                          input logic wr, input string tag, output logic [31:0] rd,
                          output int ncyc, output int nst, output int nack);
        int s0, a0;
        @(negedge clk);
        s0 = n_start;
        a0 = acks;
        bif.b_addr    = addr;
        bif.b_wdata   = wd;
        bif.b_bytesel = be;
        bif.b_wr_en   = wr;
        bif.b_access  = 1'b1;
        wait_ack(tag, rd, ncyc);
        repeat (2) @(negedge clk);
        nst  = n_start - s0;
        nack = acks - a0;
    endtask

    initial begin
        logic [31:0] rd;
        int ncyc, nst, nack, s0, a0, bad_issue, bad_ready, n;

        bif.b_addr = '0; bif.b_wdata = '0; bif.b_bytesel = '0;
        bif.b_wr_en = 1'b0; bif.b_access = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst b_ready", {31'h0, bif.b_ready}, 32'h0);
        chk("rst b_ack", {31'h0, bif.b_ack}, 32'h0);
        chk("rst h_bytesel", {30'h0, bif.h_bytesel}, 32'h0);
        chk("rst h_wr_en", {31'h0, bif.h_wr_en}, 32'h0);
        chk("rst h_addr", bif.h_addr, 32'h0);
        chk("rst h_wdata", {16'h0, bif.h_wdata}, 32'h0);
        chk("rst b_rdata", bif.b_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Init hold-off with the full write request raised early and held.
        while (cyc < 10) @(negedge clk);
        s0 = n_start; a0 = acks;
        bif.b_addr = 32'h0000_0104; bif.b_wdata = 32'hDEAD_BEEF;
        bif.b_bytesel = 4'hF; bif.b_wr_en = 1'b1; bif.b_access = 1'b1;
        bad_issue = 0; bad_ready = 0;
        while (cyc < INIT_CYCLES - 1) begin
            @(negedge clk);
            inj_compl = (cyc == 2999);
            if (bif.h_bytesel != 2'b00) bad_issue++;
            if (bif.b_ready) bad_ready++;
        end
        inj_compl = 1'b0;
        chk("init no h_bytesel", bad_issue, 0);
        chk("init no b_ready", bad_ready, 0);
        chk("init no b_ack", acks - a0, 0);
        @(negedge clk);
        chk("b_ready at INIT_CYCLES", {31'h0, bif.b_ready}, 32'h1);
        chk("no issue at ready edge", {30'h0, bif.h_bytesel}, 32'h0);
        wait_ack("wr32", rd, ncyc);
        repeat (2) @(negedge clk);
        chk("wr32 starts", n_start - s0, 2);
        chk("wr32 acks", acks - a0, 1);
        chk("wr32 b_rdata", rd, 32'h0);
        chk("wr32 lo addr", lg_addr[s0 % 16], 32'h0000_0104);
        chk("wr32 lo wdata", {16'h0, lg_wd[s0 % 16]}, 32'h0000_BEEF);
        chk("wr32 lo be", {30'h0, lg_be[s0 % 16]}, 32'h3);
        chk("wr32 lo wr", {31'h0, lg_wr[s0 % 16]}, 32'h1);
        chk("wr32 hi addr", lg_addr[(s0 + 1) % 16], 32'h0000_0106);
        chk("wr32 hi wdata", {16'h0, lg_wd[(s0 + 1) % 16]}, 32'h0000_DEAD);
        chk("wr32 hi be", {30'h0, lg_be[(s0 + 1) % 16]}, 32'h3);

        // Full read.
        rd_lo = 16'h1234; rd_hi = 16'h5678;
        s0 = n_start;
        do_acc(32'h0000_0200, 32'h0, 4'hF, 1'b0, "rd32", rd, ncyc, nst, nack);
        chk("rd32 b_rdata", rd, 32'h5678_1234);
        chk("rd32 starts", nst, 2);
        chk("rd32 acks", nack, 1);
        chk("rd32 lo wr", {31'h0, lg_wr[s0 % 16]}, 32'h0);

        // High byte only.
        rd_hi = 16'hABCD;
        s0 = n_start;
        do_acc(32'h0000_0300, 32'h0, 4'b1000, 1'b0, "rdb3", rd, ncyc, nst, nack);
        chk("rdb3 b_rdata", rd, 32'hABCD_0000);
        chk("rdb3 starts", nst, 1);
        chk("rdb3 h_addr", lg_addr[s0 % 16], 32'h0000_0302);
        chk("rdb3 h_bytesel", {30'h0, lg_be[s0 % 16]}, 32'h2);

        // Low halfword only.
        rd_lo = 16'h4321;
        do_acc(32'h0000_0310, 32'h0, 4'b0011, 1'b0, "rdlo", rd, ncyc, nst, nack);
        chk("rdlo b_rdata", rd, 32'h0000_4321);
        chk("rdlo starts", nst, 1);

        // No byte enables: no controller access, ack in the second cycle.
        do_acc(32'h0000_0320, 32'h0, 4'b0000, 1'b0, "be0", rd, ncyc, nst, nack);
        chk("be0 latency", ncyc, 2);
        chk("be0 starts", nst, 0);
        chk("be0 acks", nack, 1);
        chk("be0 b_rdata", rd, 32'h0);

        // Reset while the HI half of a write is in flight.
        @(negedge clk);
        a0 = acks;
        bif.b_addr = 32'h0000_0400; bif.b_wdata = 32'hCAFE_F00D;
        bif.b_bytesel = 4'hF; bif.b_wr_en = 1'b1; bif.b_access = 1'b1;
        n = 0;
        while (!(m_busy && m_addr == 32'h0000_0402) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst hi reached", {31'h0, m_busy}, 32'h1);
        #1 rst_n = 1'b0;
        bif.b_access = 1'b0;
        #1;
        chk("rst mid h_wr_en", {31'h0, bif.h_wr_en}, 32'h0);
        chk("rst mid h_bytesel", {30'h0, bif.h_bytesel}, 32'h0);
        chk("rst mid b_ready", {31'h0, bif.b_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        while (cyc < INIT_CYCLES) @(negedge clk);
        chk("rst trailing compl ignored", acks - a0, 0);
        chk("rst b_ready again", {31'h0, bif.b_ready}, 32'h1);

        rd_lo = 16'h9999;
        s0 = n_start;
        do_acc(32'h0000_0500, 32'h0, 4'b0011, 1'b0, "post-rst", rd, ncyc, nst, nack);
        chk("post-rst b_rdata", rd, 32'h0000_9999);
        chk("post-rst starts", nst, 1);
        chk("post-rst h_addr", lg_addr[s0 % 16], 32'h0000_0500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
